// File: rtl/seq_decoder_pkg.sv
// Shared mode/state encodings and width helper for the registered select decoder.
package seq_decoder_pkg;

  localparam logic [1:0] MODE_OFF       = 2'b00;
  localparam logic [1:0] MODE_DIRECT    = 2'b01;
  localparam logic [1:0] MODE_SCAN_UP   = 2'b10;
  localparam logic [1:0] MODE_SCAN_DOWN = 2'b11;

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/seq_decoder_n_if.sv
// Control/select bundle between a driver and the seq_decoder_n block.
interface seq_decoder_n_if #(parameter int N = 2);
  logic              en;
  logic [1:0]        mode;
  logic [N-1:0]      a;
  logic              load;
  logic [2**N-1:0]   b;
  logic [N-1:0]      idx;
  logic              valid;
  logic              wrap;

  modport master (output en, mode, a, load, input  b, idx, valid, wrap);
  modport slave  (input  en, mode, a, load, output b, idx, valid, wrap);
endinterface

// File: rtl/onehot_dec.sv
// Combinational N-to-2^N decode; ACTIVE_LOW inverts every line (one-cold).
module onehot_dec #(
  parameter int N          = 2,
  parameter int ACTIVE_LOW = 0
) (
  input  logic [N-1:0]    sel,
  output logic [2**N-1:0] y
);
  localparam int W = 2**N;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] POL = (ACTIVE_LOW != 0) ? '1 : '0;

  assign y = (ONE << sel) ^ POL;
endmodule

// File: rtl/seq_decoder_n.sv
// Registered N-to-2^N select decoder with off, direct-load and up/down auto-scan modes.
module seq_decoder_n
  import seq_decoder_pkg::*;
#(
  parameter int N          = 2,
  parameter int ACTIVE_LOW = 0,
  parameter int DWELL      = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_decoder_n_if.slave bus
);
  localparam int W  = 2**N;
  localparam int CW = clog2(DWELL + 1);
  localparam logic [CW-1:0] DLAST = CW'(DWELL - 1);
  localparam logic [W-1:0]  INACT = (ACTIVE_LOW != 0) ? '1 : '0;

  state_t        state, state_nxt;
  logic          dir_q;
  logic [N-1:0]  idx_q, idx_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic          wrap_q, wrap_nxt, valid_q, chg, up;
  logic [W-1:0]  b_q, dec;

  // Decode the index that will be registered, so b tracks idx in the same edge.
  onehot_dec #(.N(N), .ACTIVE_LOW(ACTIVE_LOW)) u_dec (.sel(idx_nxt), .y(dec));

  always_comb begin
    state_nxt = IDLE;
    idx_nxt   = idx_q;
    cnt_nxt   = '0;
    wrap_nxt  = 1'b0;
    up        = (bus.mode == MODE_SCAN_UP);
    case (bus.mode)
      MODE_OFF:    state_nxt = IDLE;
      MODE_DIRECT: state_nxt = DIRECT;
      default:     state_nxt = SCAN;
    endcase
    // Flipping scan direction counts as a mode change even though state stays SCAN.
    chg = (state_nxt != state) || (state_nxt == SCAN && dir_q != bus.mode[0]);
    case (state_nxt)
      IDLE: ;
      DIRECT: if (bus.load) idx_nxt = bus.a;
      default: begin
        if (bus.load) idx_nxt = bus.a;
        else if (!chg) begin
          if (cnt_q == DLAST) begin
            idx_nxt  = up ? idx_q + 1'b1 : idx_q - 1'b1;
            wrap_nxt = up ? &idx_q : ~|idx_q;
          end else begin
            cnt_nxt = cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dir_q   <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      valid_q <= 1'b0;
      b_q     <= INACT;
    end else if (bus.en) begin
      state  <= state_nxt;
      dir_q  <= bus.mode[0];
      idx_q  <= idx_nxt;
      cnt_q  <= cnt_nxt;
      wrap_q <= wrap_nxt;
      if (state_nxt == IDLE) begin
        valid_q <= 1'b0;
        b_q     <= INACT;
      end else begin
        valid_q <= 1'b1;
        b_q     <= dec;
      end
    end
  end

  assign bus.b     = b_q;
  assign bus.idx   = idx_q;
  assign bus.valid = valid_q;
  assign bus.wrap  = wrap_q;
endmodule

// File: doc/seq_decoder_n.md
Name: seq_decoder_n

Overview:
- Parametrised, registered N-to-2^N one-hot decoder. It is the clocked successor to the team's fixed 2-to-4 switch-level decoder.
- Adds three things the fixed decoder lacks: selectable output polarity, a direct-load mode, and an auto-scanning mode (up or down) with programmable dwell.
- Intended uses: row/column select, LED/segment digit scanning and chip-select sequencing in the education designs.

Parameters:
- N, 2, address width; the output has 2^N lines (N from 1 to 6).
- ACTIVE_LOW, 0, output polarity. 0 = selected line is 1, others 0. 1 = selected line is 0, others 1.
- DWELL, 1, clock cycles spent on each index in scan mode (1 to 65535).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  clock enable. When 0, all state is frozen and outputs are held.
- mode  in  2  00 OFF, 01 DIRECT, 10 SCAN_UP, 11 SCAN_DOWN.
- a  in  N  address for load.
- load  in  1  load strobe; samples a when en=1.
- b  out  2^N  registered one-hot (or one-cold) select outputs.
- idx  out  N  registered current index.
- valid  out  1  high when b carries an active selection.
- wrap  out  1  one-cycle pulse on scan wrap-around.

Behaviour:
- Reset (rst_n=0, asynchronous): b = all inactive (all 0, or all 1 if ACTIVE_LOW); idx = 0; valid = 0; wrap = 0; state = IDLE; dwell counter = 0.
- Releasing reset takes effect on the next rising clk edge. Reset asserted mid-scan clears everything immediately.
- All outputs are registered. b is always the decode of idx with polarity applied, whenever valid=1.
- en=0: no state changes, no wrap pulse; outputs hold their values. wrap is forced to 0 on the following edge only when en=1.
- State machine: IDLE, DIRECT, SCAN. The state follows mode on each enabled edge: 00 -> IDLE, 01 -> DIRECT, 1x -> SCAN.
- IDLE: b inactive, valid=0, idx held, load ignored.
- DIRECT:
  - On an enabled edge with load=1: idx<=a, b<=decode(a), valid<=1.
  - Latency is one cycle from load to b.
  - Without load, the previous selection is held. On entry from IDLE without load, valid=1 shows the held idx.
- SCAN:
  - valid=1. The dwell counter counts 0..DWELL-1. When it reaches DWELL-1, idx steps (+1 for SCAN_UP, -1 for SCAN_DOWN) and the counter returns to 0.
  - Step arithmetic is modulo 2^N.
  - wrap is a one-cycle pulse on the edge where idx goes 2^N-1 -> 0 (up) or 0 -> 2^N-1 (down).
  - DWELL=1 steps every enabled cycle.
- load in SCAN: idx<=a, dwell counter<=0, no wrap pulse. Load has priority over a same-cycle step.
- Any mode change (including SCAN_UP <-> SCAN_DOWN) clears the dwell counter to 0. idx is retained unless load is also asserted.
- Simultaneous load and mode change: the new mode applies and a is loaded in the same edge. Exception: load is ignored if the new mode is OFF.
- Dwell counter width is ceil(log2(DWELL+1)).
- No combinational path from any input to any output.

Decomposition:
- Package seq_decoder_pkg:
  - mode constants MODE_OFF, MODE_DIRECT, MODE_SCAN_UP, MODE_SCAN_DOWN;
  - state encoding IDLE, DIRECT, SCAN;
  - a width function clog2.
- Sub-module onehot_dec: purely combinational N-to-2^N decode with an ACTIVE_LOW parameter. It is instantiated once and feeds the b register.

Test Plan:
- Reset/polarity: rst_n=0 with ACTIVE_LOW=0 -> b=4'b0000, valid=0, idx=0. Repeat with ACTIVE_LOW=1 -> b=4'b1111.
- Direct load, N=2: mode=01, load=1, a=2 -> one cycle later b=4'b0100, idx=2, valid=1. Drop load -> b stays 4'b0100.
- Scan up, DWELL=3, N=2:
  - from idx=3, mode=10 -> idx stays 3 for 3 cycles, then 0 with wrap=1 for exactly one cycle;
  - then b=0001, 0010, 0100 at 3-cycle spacing.
- Scan down with load priority, DWELL=1: mode=11, idx=0 -> next idx=3 with wrap=1. Load a=1 on the cycle a step is due -> idx=1, no wrap, next step gives 0.
- Enable freeze: mid-scan en=0 for 5 cycles -> b, idx and the dwell position unchanged, wrap=0. After en=1, the scan resumes with the remaining dwell.
- Async reset mid-scan: rst_n pulsed low between clock edges at idx=2 -> b inactive and valid=0 immediately, without waiting for a clk edge. After release and one edge with mode=10, the scan restarts from idx=0.
